// File: rtl/sobel_seq_pkg.sv
// rtl/sobel_seq_pkg.sv - shared types and sizing helpers for the Sobel stream sequencer
package sobel_seq_pkg;

  localparam int PIX_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } seq_state_t;

  function automatic int col_w(input int img_w);
    return (img_w > 1) ? $clog2(img_w) : 1;
  endfunction

  function automatic int row_w(input int img_h);
    return (img_h > 1) ? $clog2(img_h) : 1;
  endfunction

endpackage

// File: rtl/core_sobel.sv
// rtl/core_sobel.sv - combinational 3x3 Sobel magnitude |gx|+|gy| saturated to 8 bits
module core_sobel (
  input  logic [7:0] p00,
  input  logic [7:0] p01,
  input  logic [7:0] p02,
  input  logic [7:0] p10,
  input  logic [7:0] p12,
  input  logic [7:0] p20,
  input  logic [7:0] p21,
  input  logic [7:0] p22,
  output logic [7:0] mag
);

  logic [9:0]  pos_x, neg_x, pos_y, neg_y;
  logic [9:0]  abs_x, abs_y;
  logic [10:0] sum;

  always_comb begin
    pos_x = {2'b00, p02} + {1'b0, p12, 1'b0} + {2'b00, p22};
    neg_x = {2'b00, p00} + {1'b0, p10, 1'b0} + {2'b00, p20};
    pos_y = {2'b00, p20} + {1'b0, p21, 1'b0} + {2'b00, p22};
    neg_y = {2'b00, p00} + {1'b0, p01, 1'b0} + {2'b00, p02};
    abs_x = (pos_x >= neg_x) ? (pos_x - neg_x) : (neg_x - pos_x);
    abs_y = (pos_y >= neg_y) ? (pos_y - neg_y) : (neg_y - pos_y);
    sum   = {1'b0, abs_x} + {1'b0, abs_y};
    mag   = (sum > 11'd255) ? 8'hFF : sum[7:0];
  end

endmodule

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one image line of pixels, synchronous write, combinational read
module sobel_line_buffer
  import sobel_seq_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents, so a shared address gives read-before-write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_stream_sequencer.sv
// rtl/sobel_stream_sequencer.sv - streams a raster frame through core_sobel with two line buffers
module sobel_stream_sequencer
  import sobel_seq_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int COL_W = col_w(IMG_W);
  localparam int ROW_W = row_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  seq_state_t       state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             input_exhausted;

  // Window: hist holds the two older columns; the right column is live (line buffers + in_data).
  logic [2:0][1:0][PIX_W-1:0] hist;
  logic [2:0][PIX_W-1:0]      live;
  logic [PIX_W-1:0]           lb_old_rd, lb_new_rd, sobel_mag;
  logic                       in_accept, out_accept, at_last_pix, produce;

  assign in_ready    = (state == ACTIVE) && (!out_valid || out_ready) && !input_exhausted;
  assign in_accept   = in_valid && in_ready;
  assign out_accept  = out_valid && out_ready;
  assign at_last_pix = (row == ROW_LAST) && (col == COL_LAST);
  assign produce     = in_accept && (row >= ROW_TWO) && (col >= COL_TWO);
  assign live        = {in_data, lb_new_rd, lb_old_rd};

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (COL_W)
  ) u_lb_old (
    .clk   (clk),
    .we    (in_accept),
    .addr  (col),
    .wdata (lb_new_rd),
    .rdata (lb_old_rd)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .AW    (COL_W)
  ) u_lb_new (
    .clk   (clk),
    .we    (in_accept),
    .addr  (col),
    .wdata (in_data),
    .rdata (lb_new_rd)
  );

  core_sobel u_core (
    .p00 (hist[0][0]),
    .p01 (hist[0][1]),
    .p02 (live[0]),
    .p10 (hist[1][0]),
    .p12 (live[1]),
    .p20 (hist[2][0]),
    .p21 (hist[2][1]),
    .p22 (live[2]),
    .mag (sobel_mag)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      col             <= '0;
      row             <= '0;
      input_exhausted <= 1'b0;
      hist            <= '0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= ACTIVE;
            busy            <= 1'b1;
            col             <= '0;
            row             <= '0;
            input_exhausted <= 1'b0;
          end
        end

        ACTIVE: begin
          if (in_accept) begin
            for (int r = 0; r < 3; r++) begin
              hist[r][0] <= hist[r][1];
              hist[r][1] <= live[r];
            end
            if (at_last_pix) begin
              input_exhausted <= 1'b1;
              col             <= '0;
              row             <= '0;
            end else if (col == COL_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end

          // A new result may replace one being accepted in the same cycle, keeping full rate.
          if (produce) begin
            out_data  <= sobel_mag;
            out_valid <= 1'b1;
            out_last  <= at_last_pix;
          end else if (out_accept) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end

          if (out_accept && out_last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_sequencer.sv
// tb/tb_sobel_stream_sequencer.sv - directed self-checking bench for sobel_stream_sequencer
module tb_sobel_stream_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready, out_valid, out_last, busy, frame_done;
  logic [7:0] out_data;

  logic       s_start, s_in_valid, s_out_ready;
  logic [7:0] s_in_data;
  logic       s_in_ready, s_out_valid, s_out_last, s_busy, s_frame_done;
  logic [7:0] s_out_data;

  int checks = 0;
  int errors = 0;

  logic [7:0] img [6][8];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  int last_idx, last_cyc, done_cyc;

  always #5 clk = ~clk;

  sobel_stream_sequencer #(.IMG_W(8), .IMG_H(6)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done)
  );

  sobel_stream_sequencer #(.IMG_W(3), .IMG_H(3)) u_min (
    .clk        (clk),
    .reset      (reset),
    .start      (s_start),
    .in_data    (s_in_data),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .out_data   (s_out_data),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .out_last   (s_out_last),
    .busy       (s_busy),
    .frame_done (s_frame_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] sobel_ref(input int r, input int c);
    int gx, gy, s;
    gx = (int'(img[r-1][c+1]) + 2 * int'(img[r][c+1]) + int'(img[r+1][c+1]))
       - (int'(img[r-1][c-1]) + 2 * int'(img[r][c-1]) + int'(img[r+1][c-1]));
    gy = (int'(img[r+1][c-1]) + 2 * int'(img[r+1][c]) + int'(img[r+1][c+1]))
       - (int'(img[r-1][c-1]) + 2 * int'(img[r-1][c]) + int'(img[r-1][c+1]));
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic build_model_exp();
    exp_q.delete();
    for (int r = 1; r < 5; r++)
      for (int c = 1; c < 7; c++)
        exp_q.push_back(sobel_ref(r, c));
  endtask

  // Drives one frame into u_dut while collecting outputs; optional backpressure, abort and restart.
  task automatic run_frame(input bit bp, input int abort_after, input int restart_cyc);
    int pr, pc, accepts;
    bit held, seen_done;
    logic [7:0] held_data;
    got.delete();
    last_idx = -1; last_cyc = -1; done_cyc = -1;
    pr = 0; pc = 0; accepts = 0; held = 0; seen_done = 0; held_data = 8'h00;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 3000 && !seen_done; cyc++) begin
      start     = (cyc == restart_cyc);
      in_valid  = (pr < 6) && (!bp || ($urandom_range(0, 2) != 0));
      in_data   = (pr < 6) ? img[pr][pc] : 8'h00;
      out_ready = !bp || ($urandom_range(0, 1) == 1);
      #1;
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held_data));
      end
      if (frame_done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
        check("busy_in_done", 32'(busy), 32'd1);
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) begin
          last_idx = got.size() - 1;
          last_cyc = cyc;
        end
      end
      held      = out_valid && !out_ready;
      held_data = out_data;
      if (in_valid && in_ready) begin
        accepts++;
        if (pc == 7) begin pc = 0; pr++; end
        else pc++;
      end
      @(negedge clk);
      if (abort_after > 0 && accepts == abort_after) begin
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", 32'(out_data), 32'd0);
        check("abort_out_last", 32'(out_last), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        return;
      end
    end
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("frame_done_seen", 32'(seen_done), 32'd1);
  endtask

  task automatic verify_frame(input string tag);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s_out%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_last_idx"}, 32'(last_idx), 32'(exp_q.size() - 1));
    check({tag, "_done_delay"}, 32'(done_cyc - last_cyc), 32'd1);
    #1;
    check({tag, "_done_pulse_end"}, 32'(frame_done), 32'd0);
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int k, cnt;
    bit sdone;
    logic [7:0] sval;
    logic slast;
    logic [7:0] step_row [6];

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    s_start = 1'b0; s_in_valid = 1'b0; s_in_data = 8'h00; s_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Minimum 3x3 frame, pixels 1..9: gx = 24-16 = 8, gy = 32-8 = 24, magnitude 32.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    k = 0; cnt = 0; sdone = 1'b0; sval = 8'h00; slast = 1'b0;
    for (int cyc = 0; cyc < 40 && !sdone; cyc++) begin
      s_in_valid = (k < 9);
      s_in_data  = 8'(k + 1);
      #1;
      if (s_out_valid && s_out_ready) begin
        cnt++;
        sval  = s_out_data;
        slast = s_out_last;
      end
      if (s_frame_done) sdone = 1'b1;
      if (s_in_valid && s_in_ready) k++;
      @(negedge clk);
    end
    s_in_valid = 1'b0;
    check("min_count", 32'(cnt), 32'd1);
    check("min_value", 32'(sval), 32'd32);
    check("min_last", 32'(slast), 32'd1);
    check("min_frame_done", 32'(sdone), 32'd1);

    // Constant frame: every window is flat, so all 24 outputs are zero.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 8'h55;
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(8'h00);
    run_frame(1'b0, 0, -1);
    verify_frame("const");

    // Vertical step 0|20 between columns 3 and 4: centres 3 and 4 see gx = 4*20 = 80.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = (c >= 4) ? 8'd20 : 8'd0;
    step_row = '{8'd0, 8'd0, 8'd80, 8'd80, 8'd0, 8'd0};
    exp_q.delete();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        exp_q.push_back(step_row[c]);
    run_frame(1'b0, 0, -1);
    verify_frame("step");

    // Ramp frame with saturating horizontal gradient.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 8; c++)
        img[r][c] = 8'(r * 8 + c * c * 3);
    build_model_exp();

    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    run_frame(1'b0, 0, 10);
    verify_frame("ramp_full");

    run_frame(1'b1, 0, -1);
    verify_frame("ramp_bp");

    run_frame(1'b0, 20, -1);
    run_frame(1'b0, 0, -1);
    verify_frame("after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
